// File: rtl/mem_ctrl_pkg.sv
// Shared opcodes, controller states and byte-lane helpers for the byte-serial
// memory controller and its size/extension decoder.
package mem_ctrl_pkg;

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2,
    MEM_FETCH = 2'd3
  } mem_state_e;

  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = word;
    w[{idx, 3'b000} +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/mem_ctrl_ext.sv
// Decodes the transfer size from a memory opcode and sign/zero-extends the
// assembled load word to 32 bits.
module mem_ext
  import mem_ctrl_pkg::*;
(
  input  logic [5:0]  mem_op,
  input  logic [31:0] raw,
  output logic [2:0]  size,
  output logic [31:0] ext
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    size = 3'd4;
    ext  = raw;
    case (mem_op)
      OP_LB:  begin size = 3'd1; ext = {{24{raw[7]}}, raw[7:0]};   end
      OP_LBU: begin size = 3'd1; ext = {24'd0, raw[7:0]};          end
      OP_SB:  begin size = 3'd1;                                    end
      OP_LH:  begin size = 3'd2; ext = {{16{raw[15]}}, raw[15:0]}; end
      OP_LHU: begin size = 3'd2; ext = {16'd0, raw[15:0]};         end
      OP_SH:  begin size = 3'd2;                                    end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates data loads/stores and instruction
// fetches onto one byte-wide RAM/IO port, one byte per cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        request,
  input  logic        load_or_store,
  input  logic [5:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        mem_valid,
  output logic [31:0] mem_val,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_inst,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  input  logic        io_buffer_full
);

  mem_state_e  state, next_state;
  logic [2:0]  cnt, cnt_inc, size, xfer_n;
  logic [31:0] addr_q, data_q, asm_q, asm_next, addr_inc, ext_val;
  logic [5:0]  op_q;
  logic        kill_q;
  logic        io_block, data_go, fetch_go, last;
  logic        load_done, fetch_done, store_done, store_ack;

  mem_ext u_ext (
    .mem_op (op_q),
    .raw    (asm_next),
    .size   (size),
    .ext    (ext_val)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     state <= MEM_IDLE;
    else if (rdy_in) state <= next_state;
  end

  always_comb begin
    io_block   = load_or_store && (mem_addr >= IO_BASE) && io_buffer_full;
    data_go    = request && !mem_valid && !io_block && !clear;
    fetch_go   = !data_go && if_req && !if_valid && !clear;
    xfer_n     = (state == MEM_FETCH) ? 3'd4 : size;
    last       = (cnt == xfer_n - 3'd1);
    next_state = state;
    case (state)
      MEM_IDLE: begin
        if (data_go)       next_state = load_or_store ? MEM_STORE : MEM_LOAD;
        else if (fetch_go) next_state = MEM_FETCH;
      end
      MEM_LOAD, MEM_FETCH: if (clear || last) next_state = MEM_IDLE;
      MEM_STORE:           if (last)          next_state = MEM_IDLE;
      default:             next_state = MEM_IDLE;
    endcase
  end

  // A store already on the bus is committed: clear only silences its ack.
  always_comb begin
    cnt_inc    = cnt + 3'd1;
    addr_inc   = addr_q + {29'd0, cnt_inc};
    asm_next   = put_byte(asm_q, cnt[1:0], ram_din);
    load_done  = (state == MEM_LOAD)  && last && !clear;
    fetch_done = (state == MEM_FETCH) && last && !clear;
    store_done = (state == MEM_STORE) && last;
    store_ack  = store_done && !clear && !kill_q;
  end

  // NOTE: the assembly buffer is a single register, so it is reset along with
  // the rest of the datapath; only large storage arrays skip reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      asm_q     <= '0;
      op_q      <= '0;
      kill_q    <= 1'b0;
      mem_valid <= 1'b0;
      mem_val   <= '0;
      if_valid  <= 1'b0;
      if_inst   <= '0;
      ram_dout  <= '0;
      ram_a     <= '0;
      ram_wr    <= 1'b0;
    end else if (rdy_in) begin
      mem_valid <= load_done || store_ack;
      if_valid  <= fetch_done;
      case (state)
        MEM_IDLE: begin
          if (data_go || fetch_go) begin
            cnt    <= '0;
            asm_q  <= '0;
            kill_q <= 1'b0;
          end
          if (data_go) begin
            addr_q   <= mem_addr;
            data_q   <= mem_data;
            op_q     <= mem_op;
            ram_a    <= mem_addr;
            ram_wr   <= load_or_store;
            ram_dout <= mem_data[7:0];
          end else if (fetch_go) begin
            addr_q <= if_addr;
            ram_a  <= if_addr;
            ram_wr <= 1'b0;
          end
        end
        MEM_LOAD, MEM_FETCH: begin
          if (!clear) begin
            asm_q <= asm_next;
            if (!last) begin
              cnt   <= cnt_inc;
              ram_a <= addr_inc;
            end
          end
        end
        MEM_STORE: begin
          if (clear) kill_q <= 1'b1;
          if (last) begin
            ram_wr <= 1'b0;
          end else begin
            cnt      <= cnt_inc;
            ram_a    <= addr_inc;
            ram_dout <= get_byte(data_q, cnt_inc[1:0]);
          end
        end
        default: ;
      endcase
      if (load_done)  mem_val <= ext_val;
      if (store_ack)  mem_val <= '0;
      if (fetch_done) if_inst <= asm_next;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized
// transactions checked against a byte-array memory model.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, request, load_or_store;
  logic [5:0]  mem_op;
  logic [31:0] mem_addr, mem_data, mem_val, if_addr, if_inst, ram_a;
  logic        mem_valid, if_req, if_valid, ram_wr, io_buffer_full;
  logic [7:0]  ram_din, ram_dout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  mem_ctrl #(.IO_BASE(IO_BASE)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .request(request), .load_or_store(load_or_store), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid),
    .mem_val(mem_val), .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid),
    .if_inst(if_inst), .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a),
    .ram_wr(ram_wr), .io_buffer_full(io_buffer_full)
  );

  // Memory model: asynchronous read, write on the clock edge; IO writes are logged.
  logic [7:0]  ram [0:4095];
  logic        fill_en, poke_en;
  logic [11:0] poke_addr;
  logic [7:0]  poke_byte;
  int          io_wr_cnt;
  logic [7:0]  io_last;

  assign ram_din = ram[ram_a[11:0]];

  always @(posedge clk_in) begin
    if (fill_en) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'($urandom);
    end else if (poke_en) begin
      ram[poke_addr] <= poke_byte;
    end else if (ram_wr) begin
      if (ram_a >= IO_BASE) begin
        io_wr_cnt <= io_wr_cnt + 1;
        io_last   <= ram_dout;
      end else begin
        ram[ram_a[11:0]] <= ram_dout;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    poke_addr = a[11:0];
    poke_byte = b;
    poke_en   = 1'b1;
    tick();
    poke_en   = 1'b0;
  endtask

  function automatic int ref_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      default:              return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    longint v = 0;
    for (int k = 0; k < n; k++) v += longint'(ram[12'(a + 32'(k))]) << (8 * k);
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] a);
    longint v;
    v = longint'(ref_word(a, ref_size(op)));
    if (op == OP_LB && v >= 128)   v -= 256;
    if (op == OP_LH && v >= 32768) v -= 65536;
    return 32'(v);
  endfunction

  function automatic logic [5:0] pick_op(input int i);
    case (i)
      0: return OP_LB;  1: return OP_LH;  2: return OP_LW;  3: return OP_LBU;
      4: return OP_LHU; 5: return OP_SB;  6: return OP_SH;  default: return OP_SW;
    endcase
  endfunction

  // One data transaction with a one-cycle cooldown where request stays high.
  task automatic run_data(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] d, input int stall);
    logic [31:0] tr_a[$];
    logic        tr_w[$];
    logic [7:0]  tr_d[$];
    logic [31:0] exp_val;
    int          n, cyc;
    bit          st;
    st      = (op == OP_SB || op == OP_SH || op == OP_SW);
    n       = ref_size(op);
    exp_val = st ? 32'd0 : ref_load(op, a);
    mem_op = op; load_or_store = st; mem_addr = a; mem_data = d; request = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (!mem_valid) begin
        tr_a.push_back(ram_a); tr_w.push_back(ram_wr); tr_d.push_back(ram_dout);
      end
      if (cyc == 1 && stall > 0) begin
        rdy_in = 1'b0;
        repeat (stall) tick();
        check({tag, " stall hold"}, ram_a, a);
        rdy_in = 1'b1;
      end
    end while (!mem_valid && cyc < 40);
    check({tag, " latency"}, cyc, n + 1);
    check({tag, " bytes"}, tr_a.size(), n);
    for (int k = 0; k < n && k < tr_a.size(); k++) begin
      check({tag, " addr"}, tr_a[k], a + 32'(k));
      check({tag, " wr"}, 32'(tr_w[k]), 32'(st));
      if (st) check({tag, " dout"}, 32'(tr_d[k]), (d >> (8 * k)) & 32'hff);
    end
    check({tag, " value"}, mem_val, exp_val);
    check({tag, " wr end"}, 32'(ram_wr), 0);
    if (st) check({tag, " stored"}, ref_word(a, n), d & 32'((64'd1 << (8 * n)) - 1));
    tick();
    check({tag, " pulse width"}, 32'(mem_valid), 0);
    check({tag, " no restart"}, ram_a, a + 32'(n - 1));
    request = 1'b0;
  endtask

  task automatic run_fetch(input string tag, input logic [31:0] a);
    logic [31:0] tr_a[$];
    logic [31:0] exp_w;
    int          cyc;
    exp_w = ref_word(a, 4);
    if_addr = a; if_req = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (!if_valid) tr_a.push_back(ram_a);
    end while (!if_valid && cyc < 40);
    check({tag, " latency"}, cyc, 5);
    check({tag, " bytes"}, tr_a.size(), 4);
    for (int k = 0; k < 4 && k < tr_a.size(); k++) check({tag, " addr"}, tr_a[k], a + 32'(k));
    check({tag, " inst"}, if_inst, exp_w);
    tick();
    check({tag, " pulse width"}, 32'(if_valid), 0);
    check({tag, " no restart"}, ram_a, a + 32'd3);
    if_req = 1'b0;
  endtask

  initial begin
    int          cyc, io0;
    bit          saw_wr, saw_mv, saw_iv;
    logic [31:0] exp_d, exp_i, a, d;

    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; request = 1'b0; load_or_store = 1'b0;
    mem_op = OP_LW; mem_addr = '0; mem_data = '0; if_req = 1'b0; if_addr = '0;
    io_buffer_full = 1'b0; poke_en = 1'b0; poke_addr = '0; poke_byte = '0; fill_en = 1'b1;
    tick();
    fill_en = 1'b0;
    tick();
    check("reset mem_valid", 32'(mem_valid), 0);
    check("reset if_valid", 32'(if_valid), 0);
    check("reset ram_wr", 32'(ram_wr), 0);
    check("reset ram_dout", 32'(ram_dout), 0);
    check("reset ram_a", ram_a, 0);
    check("reset mem_val", mem_val, 0);
    check("reset if_inst", if_inst, 0);
    rst_in = 1'b1;
    tick();

    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h84);
    run_data("lw", OP_LW, 32'h100, 32'hdead_beef, 0);
    check("lw const", mem_val, 32'h8433_2211);
    poke(32'h200, 8'h80);
    run_data("lb", OP_LB, 32'h200, 32'h0, 0);
    check("lb const", mem_val, 32'hffff_ff80);
    run_data("lbu", OP_LBU, 32'h200, 32'h0, 0);
    check("lbu const", mem_val, 32'h0000_0080);
    poke(32'h210, 8'h01); poke(32'h211, 8'h80);
    run_data("lh", OP_LH, 32'h210, 32'h0, 0);
    check("lh const", mem_val, 32'hffff_8001);
    run_data("sh", OP_SH, 32'h300, 32'h0000_beef, 0);
    check("sh byte0", 32'(ram[12'h300]), 32'hef);
    check("sh byte1", 32'(ram[12'h301]), 32'hbe);
    run_data("lhu stall", OP_LHU, 32'h210, 32'h0, 3);
    check("lhu const", mem_val, 32'h0000_8001);

    // Data and fetch requested together: data wins, fetch follows.
    exp_d = ref_load(OP_LW, 32'h400);
    exp_i = ref_word(32'h500, 4);
    mem_op = OP_LW; load_or_store = 1'b0; mem_addr = 32'h400; if_addr = 32'h500;
    request = 1'b1; if_req = 1'b1;
    cyc = 0;
    do begin tick(); cyc++; end while (!mem_valid && !if_valid && cyc < 40);
    check("both data first", 32'(mem_valid), 1);
    check("both fetch waits", 32'(if_valid), 0);
    check("both data latency", cyc, 5);
    check("both data value", mem_val, exp_d);
    tick();
    request = 1'b0;
    cyc = 1;
    while (!if_valid && cyc < 40) begin tick(); cyc++; end
    check("both fetch latency", cyc, 5);
    check("both fetch inst", if_inst, exp_i);
    tick();
    check("both fetch width", 32'(if_valid), 0);
    if_req = 1'b0;
    run_fetch("fetch", 32'h0a0);

    // Store into IO space held off by back-pressure.
    io0 = io_wr_cnt;
    io_buffer_full = 1'b1;
    mem_op = OP_SB; load_or_store = 1'b1; mem_addr = IO_BASE; mem_data = 32'h1234_565a;
    request = 1'b1;
    saw_wr = 1'b0; saw_mv = 1'b0;
    repeat (10) begin tick(); if (ram_wr) saw_wr = 1'b1; if (mem_valid) saw_mv = 1'b1; end
    check("io blocked write", 32'(saw_wr), 0);
    check("io blocked valid", 32'(saw_mv), 0);
    check("io blocked count", io_wr_cnt - io0, 0);
    io_buffer_full = 1'b0;
    cyc = 0;
    do begin tick(); cyc++; end while (!mem_valid && cyc < 40);
    check("io latency", cyc, 2);
    check("io write count", io_wr_cnt - io0, 1);
    check("io write byte", 32'(io_last), 32'h5a);
    tick();
    request = 1'b0;
    check("io pulse width", 32'(mem_valid), 0);

    // Clear during the third fetch byte aborts immediately.
    if_addr = 32'h600; if_req = 1'b1;
    repeat (3) tick();
    clear = 1'b1; if_req = 1'b0;
    tick();
    clear = 1'b0;
    check("clr fetch valid", 32'(if_valid), 0);
    check("clr fetch wr", 32'(ram_wr), 0);
    saw_iv = 1'b0;
    run_data("after clr", OP_LBU, 32'h200, 32'h0, 0);
    repeat (4) begin tick(); if (if_valid) saw_iv = 1'b1; end
    check("clr fetch late valid", 32'(saw_iv), 0);

    // Clear during a word store: all bytes land, ack suppressed.
    a = 32'h700; d = $urandom;
    mem_op = OP_SW; load_or_store = 1'b1; mem_addr = a; mem_data = d; request = 1'b1;
    repeat (2) tick();
    clear = 1'b1; request = 1'b0;
    saw_mv = 1'b0;
    tick();
    if (mem_valid) saw_mv = 1'b1;
    clear = 1'b0;
    repeat (8) begin tick(); if (mem_valid) saw_mv = 1'b1; end
    check("clr sw no valid", 32'(saw_mv), 0);
    check("clr sw bytes", ref_word(a, 4), d);

    // Asynchronous reset in the middle of a load.
    mem_op = OP_LW; load_or_store = 1'b0; mem_addr = 32'h100; request = 1'b1;
    repeat (2) tick();
    rst_in = 1'b0;
    #1;
    check("midrst mem_valid", 32'(mem_valid), 0);
    check("midrst if_valid", 32'(if_valid), 0);
    check("midrst ram_wr", 32'(ram_wr), 0);
    check("midrst ram_dout", 32'(ram_dout), 0);
    check("midrst ram_a", ram_a, 0);
    check("midrst mem_val", mem_val, 0);
    check("midrst if_inst", if_inst, 0);
    request = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    tick();
    run_data("post rst lw", OP_LW, 32'h100, 32'h0, 0);
    check("post rst const", mem_val, 32'h8433_2211);

    // Randomized mix against the memory model.
    for (int i = 0; i < 40; i++) begin
      run_data("rand data", pick_op($urandom_range(0, 7)), 32'($urandom_range(32'h000, 32'hf00)),
               $urandom, ($urandom_range(0, 4) == 0) ? 2 : 0);
      if ($urandom_range(0, 2) == 0)
        run_fetch("rand fetch", 32'($urandom_range(0, 32'h3c0)) << 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
